// File: rtl/fir_pkg.sv
// Shared constants for the FIR adder-topology comparison set.
package fir_pkg;

    localparam int CSEL_BLK = 4;

endpackage

// File: rtl/csel_adder.sv
// Signed carry-select adder: both operands are sign-extended to N+1 bits and
// added in B-bit ripple blocks whose upper blocks precompute cin=0 and cin=1.
module csel_adder
    import fir_pkg::*;
#(
    parameter int N = 16,
    parameter int B = CSEL_BLK
) (
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    output logic signed [N:0]   sum_o
);

    localparam int M  = N + 1;
    localparam int NB = (M + B - 1) / B;

    logic [M-1:0]  ax;
    logic [M-1:0]  bx;
    logic [NB-1:0] cy;

    assign ax    = {a_i[N-1], a_i};
    assign bx    = {b_i[N-1], b_i};
    assign cy[0] = 1'b0;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        localparam int LO = g * B;
        localparam int BW = ((M - LO) < B) ? (M - LO) : B;
        // The last block carries out nothing, so it is built one bit narrower.
        localparam int RW = (g < NB - 1) ? BW + 1 : BW;

        logic [BW-1:0] xa;
        logic [BW-1:0] xb;

        assign xa = ax[LO +: BW];
        assign xb = bx[LO +: BW];

        if (g == 0) begin : g_ripple
            logic [RW-1:0] r;

            assign r = RW'(xa) + RW'(xb) + RW'(cy[0]);
            assign sum_o[LO +: BW] = r[BW-1:0];
            if (g < NB - 1) begin : g_cout
                assign cy[g+1] = r[BW];
            end
        end else begin : g_select
            logic [RW-1:0] r0;
            logic [RW-1:0] r1;

            assign r0 = RW'(xa) + RW'(xb);
            assign r1 = RW'(xa) + RW'(xb) + RW'(1);
            assign sum_o[LO +: BW] = cy[g] ? r1[BW-1:0] : r0[BW-1:0];
            if (g < NB - 1) begin : g_cout
                assign cy[g+1] = cy[g] ? r1[BW] : r0[BW];
            end
        end
    end

endmodule

// File: rtl/fir4_carry_select_adder_u.sv
// 4-tap unit-coefficient FIR: s is the registered sum of the last four
// registered samples, built from a two-level carry-select adder tree.
module fir4_carry_select_adder_u
    import fir_pkg::*;
#(
    parameter int w = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [w-1:0] a,
    output logic signed [w+1:0] s
);

    logic signed [w-1:0] x1_q, x2_q, x3_q, x4_q;
    logic signed [w:0]   p;
    logic signed [w:0]   q;
    logic signed [w+1:0] s_d;
    logic signed [w+1:0] s_q;

    csel_adder #(.N(w), .B(CSEL_BLK)) u_add_p (
        .a_i   (x1_q),
        .b_i   (x2_q),
        .sum_o (p)
    );

    csel_adder #(.N(w), .B(CSEL_BLK)) u_add_q (
        .a_i   (x3_q),
        .b_i   (x4_q),
        .sum_o (q)
    );

    csel_adder #(.N(w + 1), .B(CSEL_BLK)) u_add_s (
        .a_i   (p),
        .b_i   (q),
        .sum_o (s_d)
    );

    // Reset clears taps and output together so no pre-reset sample survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
            x4_q <= '0;
            s_q  <= '0;
        end else begin
            x1_q <= a;
            x2_q <= x1_q;
            x3_q <= x2_q;
            x4_q <= x3_q;
            s_q  <= s_d;
        end
    end

    assign s = s_q;

endmodule

// File: tb/tb_fir4_carry_select_adder_u.sv
// Bench for the 4-tap carry-select FIR at w=16 and w=8 (shared clock/reset).
module tb_fir4_carry_select_adder_u;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] a16;
    logic signed [7:0]  a8;
    logic signed [17:0] s16;
    logic signed [9:0]  s8;

    int n_checks = 0;
    int n_fail   = 0;

    int h16[$];
    int h8[$];
    int e16;
    int e8;

    typedef struct {
        logic        rst;
        logic [15:0] a;
        logic [17:0] s;
    } vec_t;

    vec_t vecs[$];

    fir4_carry_select_adder_u #(.w(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .a     (a16),
        .s     (s16)
    );

    fir4_carry_select_adder_u #(.w(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .a     (a8),
        .s     (s8)
    );

    always #5 clk = ~clk;

    // Reference: s after an edge is the sum of the (up to) four most recent
    // samples captured since the last reset, taken before this edge's capture.
    function automatic int last4(input int h[$]);
        int acc;
        int lo;
        acc = 0;
        lo  = (h.size() > 4) ? h.size() - 4 : 0;
        for (int i = lo; i < h.size(); i++) acc += h[i];
        return acc;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [15:0] x16, input logic [7:0] x8);
        reset = r;
        a16   = x16;
        a8    = x8;
        @(posedge clk);
        #1;
        if (r) begin
            h16.delete();
            h8.delete();
            e16 = 0;
            e8  = 0;
        end else begin
            e16 = last4(h16);
            e8  = last4(h8);
            h16.push_back(int'($signed(x16)));
            h8.push_back(int'($signed(x8)));
        end
    endtask

    task automatic addv(input logic r, input logic [15:0] x, input logic [17:0] e);
        vec_t v;
        v.rst = r;
        v.a   = x;
        v.s   = e;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        a16   = '0;
        a8    = '0;

        // Reset, then release with a=0.
        addv(1, 16'h1234, 18'h0);
        addv(1, 16'h1234, 18'h0);
        addv(0, 16'h0000, 18'h0);
        addv(0, 16'h0000, 18'h0);
        // Impulse.
        addv(0, 16'h0001, 18'h0);
        addv(0, 16'h0000, 18'h1);
        addv(0, 16'h0000, 18'h1);
        addv(0, 16'h0000, 18'h1);
        addv(0, 16'h0000, 18'h1);
        addv(0, 16'h0000, 18'h0);
        addv(0, 16'h0000, 18'h0);
        // Max positive held.
        addv(0, 16'h7FFF, 18'h0);
        addv(0, 16'h7FFF, 18'h07FFF);
        addv(0, 16'h7FFF, 18'h0FFFE);
        addv(0, 16'h7FFF, 18'h17FFD);
        addv(0, 16'h7FFF, 18'h1FFFC);
        addv(0, 16'h7FFF, 18'h1FFFC);
        // Max negative held.
        addv(0, 16'h8000, 18'h1FFFC);
        addv(0, 16'h8000, 18'h0FFFD);
        addv(0, 16'h8000, 18'h3FFFE);
        addv(0, 16'h8000, 18'h2FFFF);
        addv(0, 16'h8000, 18'h20000);
        addv(0, 16'h8000, 18'h20000);
        // Alternating extremes settle at -2.
        addv(0, 16'h7FFF, 18'h20000);
        addv(0, 16'h8000, 18'h2FFFF);
        addv(0, 16'h7FFF, 18'h2FFFF);
        addv(0, 16'h8000, 18'h3FFFE);
        addv(0, 16'h7FFF, 18'h3FFFE);
        addv(0, 16'h8000, 18'h3FFFE);
        // Mid-stream reset discards history.
        addv(0, 16'h0100, 18'h3FFFE);
        addv(0, 16'h0100, 18'h380FF);
        addv(0, 16'h0100, 18'h001FF);
        addv(1, 16'h0100, 18'h0);
        addv(0, 16'h0001, 18'h0);
        addv(0, 16'h0001, 18'h1);
        addv(0, 16'h0001, 18'h2);
        addv(0, 16'h0001, 18'h3);
        addv(0, 16'h0001, 18'h4);
        addv(0, 16'h0001, 18'h4);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].a, 8'($urandom));
            check($sformatf("vec%0d_w16", i), int'(s16), int'($signed(vecs[i].s)));
            check($sformatf("vec%0d_w8", i), int'(s8), e8);
        end

        // Randomized stream with one reset in the middle.
        for (int i = 0; i < 40; i++) begin
            step(i == 20, 16'($urandom), 8'($urandom));
            check($sformatf("rnd%0d_w16", i), int'(s16), e16);
            check($sformatf("rnd%0d_w8", i), int'(s8), e8);
        end

        // w=8 extremes.
        for (int i = 0; i < 6; i++) begin
            step(0, 16'h7FFF, 8'h7F);
            check($sformatf("maxpos%0d_w8", i), int'(s8), e8);
        end
        check("maxpos_settle_w8", int'(s8), 508);
        for (int i = 0; i < 6; i++) begin
            step(0, 16'h8000, 8'h80);
            check($sformatf("maxneg%0d_w8", i), int'(s8), e8);
        end
        check("maxneg_settle_w8", int'(s8), -512);
        check("maxneg_settle_w16", int'(s16), -131072);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
